cla16_nibble_serial_ctrl: RTL and testbench

- Upstream sequencer and downstream collector for the registered 4-bit augmented CLA stage (2-cycle input-register/output-register latency).
- Accepts a full-width add request and feeds the stage one nibble at a time, LSB first, chaining each returned carry into the next nibble.
- Assembles the returned sum nibbles into a full-width result, along with final carry-out and group propagate/generate.
- Gives a W-bit adder from a single 4-bit CLA instance, trading area for latency.

---
 rtl/cla16_nibble_serial_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_cla16_nibble_serial_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla16_nibble_serial_ctrl.sv
// ---------------------------------------------------------------------------
// cla16_nibble_serial_ctrl
//
// Purpose:
//   Sequencer and collector around a single registered 4-bit CLA stage.
//   A full-width add request is fed to the stage one nibble at a time,
//   LSB nibble first. Each nibble's returned carry becomes the next nibble's
//   carry-in. The returned sum nibbles are assembled into a W-bit result,
//   together with the final carry-out and the group propagate/generate.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start, a, b, c_in request strobe and operands (W = 4*NIBBLES)
//   busy, done        status: busy during an operation, one-cycle done pulse
//   sum, c_out, P, G  result registers, held until the next done
//   cla_a, cla_b,     nibble operands and carry driven to the CLA stage
//   cla_cin
//   cla_sum, cla_cout,
//   cla_p, cla_g      nibble results returned by the CLA stage
//   dbg_state         current FSM state (1 = RUN), for observation only
//
// Handshake:
//   start is sampled only while idle. An accepted start raises busy on the
//   same edge. Exactly NIBBLES*(CLA_LAT+1) edges later, busy drops and done
//   pulses for one cycle with the result valid from that cycle on. start is
//   ignored while busy. start in the done cycle is accepted, which allows
//   back-to-back operation.
//
// NIBBLES must be at least 2.
// ---------------------------------------------------------------------------
module cla16_nibble_serial_ctrl #(
    parameter  int NIBBLES = 4,
    parameter  int CLA_LAT = 2,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         P,
    output logic         G,
    output logic [3:0]   cla_a,
    output logic [3:0]   cla_b,
    output logic         cla_cin,
    input  logic [3:0]   cla_sum,
    input  logic         cla_cout,
    input  logic         cla_p,
    input  logic         cla_g,
    output logic         dbg_state
);

    localparam int IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int WAIT_W = (CLA_LAT > 0) ? $clog2(CLA_LAT + 1) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CLA_LAT);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WAIT_W-1:0] wait_q;
    // Operand nibbles not yet sent to the stage. Bits [3:0] hold the next nibble.
    logic [W-5:0]      a_sh_q;
    logic [W-5:0]      b_sh_q;
    // Sum nibbles collected so far. Each new nibble enters at the top,
    // so nibble 0 reaches bit 0 after the last capture.
    logic [W-5:0]      sum_acc_q;
    logic              pacc_q;
    logic              gacc_q;

    logic              busy_q;
    logic              done_q;
    logic [W-1:0]      sum_q;
    logic              c_out_q;
    logic              p_q;
    logic              g_q;
    logic [3:0]        cla_a_q;
    logic [3:0]        cla_b_q;
    // Also serves as the running carry between nibbles.
    logic              cla_cin_q;

    logic              pacc_d;
    logic              gacc_d;
    logic [W-1:0]      sum_d;

    // The current nibble sits above everything gathered so far, so it combines
    // into the group terms as the more significant group.
    always_comb begin
        pacc_d = pacc_q & cla_p;
        gacc_d = cla_g | (cla_p & gacc_q);
        sum_d  = {cla_sum, sum_acc_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            wait_q    <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_acc_q <= '0;
            pacc_q    <= 1'b0;
            gacc_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_q     <= '0;
            c_out_q   <= 1'b0;
            p_q       <= 1'b0;
            g_q       <= 1'b0;
            cla_a_q   <= '0;
            cla_b_q   <= '0;
            cla_cin_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // Nibble 0 is presented on the accept edge itself.
                        cla_a_q   <= a[3:0];
                        cla_b_q   <= b[3:0];
                        cla_cin_q <= c_in;
                        a_sh_q    <= a[W-1:4];
                        b_sh_q    <= b[W-1:4];
                        idx_q     <= '0;
                        wait_q    <= '0;
                        pacc_q    <= 1'b1;
                        gacc_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (wait_q == WAIT_MAX) begin
                        sum_acc_q <= sum_d[W-1:4];
                        pacc_q    <= pacc_d;
                        gacc_q    <= gacc_d;
                        wait_q    <= '0;
                        if (idx_q == LAST_IDX) begin
                            // cla_* keep the last nibble while idle.
                            sum_q   <= sum_d;
                            c_out_q <= cla_cout;
                            p_q     <= pacc_d;
                            g_q     <= gacc_d;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            cla_a_q   <= a_sh_q[3:0];
                            cla_b_q   <= b_sh_q[3:0];
                            cla_cin_q <= cla_cout;
                            a_sh_q    <= a_sh_q >> 4;
                            b_sh_q    <= b_sh_q >> 4;
                            idx_q     <= idx_q + 1'b1;
                        end
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign P         = p_q;
    assign G         = g_q;
    assign cla_a     = cla_a_q;
    assign cla_b     = cla_b_q;
    assign cla_cin   = cla_cin_q;
    assign dbg_state = (state_q == RUN);

endmodule

// File: tb/tb_cla16_nibble_serial_ctrl.sv
// Testbench for cla16_nibble_serial_ctrl with a registered 4-bit CLA stage
// model (input register + output register) attached to the cla_* ports.
module tb_cla16_nibble_serial_ctrl;

    localparam int W   = 16;
    localparam int LAT = 12;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         busy, done, c_out, P, G, cla_cin, dbg_state;
    logic [W-1:0] sum;
    logic [3:0]   cla_a, cla_b;
    logic [3:0]   cla_sum;
    logic         cla_cout, cla_p, cla_g;

    cla16_nibble_serial_ctrl #(.NIBBLES(4), .CLA_LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out), .P(P), .G(G),
        .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
        .cla_sum(cla_sum), .cla_cout(cla_cout), .cla_p(cla_p), .cla_g(cla_g),
        .dbg_state(dbg_state)
    );

    // ---------------- 4-bit CLA stage model (2-cycle) ----------------
    logic [3:0] m_a, m_b;
    logic       m_c;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_a <= '0; m_b <= '0; m_c <= 1'b0;
            cla_sum <= '0; cla_cout <= 1'b0; cla_p <= 1'b0; cla_g <= 1'b0;
        end else begin
            m_a <= cla_a;
            m_b <= cla_b;
            m_c <= cla_cin;
            {cla_cout, cla_sum} <= {1'b0, m_a} + {1'b0, m_b} + {4'b0, m_c};
            cla_p <= &(m_a ^ m_b);
            cla_g <= (({1'b0, m_a} + {1'b0, m_b}) > 5'd15);
        end
    end

    // ---------------- counters / check ----------------
    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int acc_cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- reference model ----------------
    // Tracks one outstanding request by its age in cycles and derives every
    // expected output from the operands with whole-word arithmetic.
    logic         have_op = 1'b0;
    int           op_n = 0;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic         op_c = 1'b0;
    logic         e_busy = 1'b0, e_done = 1'b0, e_cout = 1'b0, e_p = 1'b0, e_g = 1'b0;
    logic [W-1:0] e_sum = '0;
    logic [3:0]   e_cla_a = '0, e_cla_b = '0;
    logic         e_cla_cin = 1'b0;

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic set_cla(input int k);
        logic [W:0] mask, t;
        mask      = ({{W{1'b0}}, 1'b1} << (4 * k)) - 1'b1;
        t         = ({1'b0, op_a} & mask) + ({1'b0, op_b} & mask) + {{W{1'b0}}, op_c};
        e_cla_a   = 4'(op_a >> (4 * k));
        e_cla_b   = 4'(op_b >> (4 * k));
        e_cla_cin = t[4 * k];
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            have_op = 1'b0; op_n = 0;
            e_busy = 1'b0; e_done = 1'b0; e_sum = '0; e_cout = 1'b0;
            e_p = 1'b0; e_g = 1'b0; e_cla_a = '0; e_cla_b = '0; e_cla_cin = 1'b0;
        end else begin
            e_done = 1'b0;
            if (have_op) begin
                op_n++;
                if (op_n == LAT) begin
                    logic [W:0] r, r0;
                    r      = ref_add(op_a, op_b, op_c);
                    r0     = ref_add(op_a, op_b, 1'b0);
                    e_sum  = r[W-1:0];
                    e_cout = r[W];
                    e_p    = ((op_a ^ op_b) == {W{1'b1}});
                    e_g    = r0[W];
                    e_done = 1'b1;
                    have_op = 1'b0;
                end else begin
                    set_cla(op_n / 3);
                end
            end else if (start) begin
                op_a = a; op_b = b; op_c = c_in;
                have_op = 1'b1;
                op_n = 0;
                set_cla(0);
            end
            e_busy = have_op;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        chk("busy",    32'(busy),    32'(e_busy));
        chk("done",    32'(done),    32'(e_done));
        chk("sum",     32'(sum),     32'(e_sum));
        chk("c_out",   32'(c_out),   32'(e_cout));
        chk("P",       32'(P),       32'(e_p));
        chk("G",       32'(G),       32'(e_g));
        chk("cla_a",   32'(cla_a),   32'(e_cla_a));
        chk("cla_b",   32'(cla_b),   32'(e_cla_b));
        chk("cla_cin", 32'(cla_cin), 32'(e_cla_cin));
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
        a = xa; b = xb; c_in = xc; start = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        start = 1'b0;
    endtask

    // Returns in the done cycle (at its negedge), or after the budget expires.
    task automatic wait_done(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk({name, "_done_seen"}, 32'(done), 32'd1);
        chk({name, "_latency"}, 32'(cyc - acc_cyc), 32'(LAT));
    endtask

    task automatic chk_result(input string name, input logic [W-1:0] s, input logic co,
                              input logic p, input logic g);
        chk({name, "_sum"}, 32'(sum), 32'(s));
        chk({name, "_cout"}, 32'(c_out), 32'(co));
        chk({name, "_P"}, 32'(P), 32'(p));
        chk({name, "_G"}, 32'(G), 32'(g));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Plain add, no carries.
        do_start(16'h1234, 16'h4321, 1'b0);
        wait_done("t1");
        chk_result("t1", 16'h5555, 1'b0, 1'b0, 1'b0);

        // Ripple out of the LSB nibble; watch the carry into each nibble window.
        do_start(16'hFFFF, 16'h0001, 1'b0);
        @(negedge clk);
        chk("t2_cin0", 32'(cla_cin), 32'd0);
        for (int k = 1; k < 4; k++) begin
            repeat (3) @(negedge clk);
            chk("t2_cin", 32'(cla_cin), 32'd1);
        end
        wait_done("t2");
        chk_result("t2", 16'h0000, 1'b1, 1'b0, 1'b1);

        // Full propagate chain fed by c_in.
        do_start(16'hF0F0, 16'h0F0F, 1'b1);
        wait_done("t3");
        chk_result("t3", 16'h0000, 1'b1, 1'b1, 1'b0);

        // start held for five edges; later edges must be ignored.
        a = 16'h0001; b = 16'h0001; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        a = 16'hAAAA;
        repeat (4) @(posedge clk);
        #1 start = 1'b0;
        wait_done("t4a");
        chk_result("t4a", 16'h0002, 1'b0, 1'b0, 1'b0);
        // Re-raise in the done cycle: accepted on the very next edge.
        do_start(16'h00FF, 16'h0001, 1'b0);
        chk("t4b_busy", 32'(busy), 32'd1);
        wait_done("t4b");
        chk_result("t4b", 16'h0100, 1'b0, 1'b0, 1'b0);

        // Reset in mid-operation.
        do_start(16'h1111, 16'h2222, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk_result("t5", 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("t5_cla_a", 32'(cla_a), 32'd0);
        chk("t5_cla_b", 32'(cla_b), 32'd0);
        chk("t5_cla_cin", 32'(cla_cin), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("t5_no_done", 32'(done), 32'd0);
        end
        do_start(16'h1111, 16'h2222, 1'b1);
        wait_done("t5b");
        chk_result("t5b", 16'h3334, 1'b0, 1'b0, 1'b0);

        // Random operands, mixing back-to-back and gapped requests.
        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            logic [W:0]   r;
            ra = W'($urandom_range(0, 65535));
            rb = W'($urandom_range(0, 65535));
            rc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
            do_start(ra, rb, rc);
            wait_done("rnd");
            r = ref_add(ra, rb, rc);
            chk("rnd_sum", 32'(sum), 32'(r[W-1:0]));
            chk("rnd_cout", 32'(c_out), 32'(r[W]));
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
